// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm scheduler: FSM encoding, slot geometry
// and the default reschedule interval for daily-repeating slots.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RING = 2'd2
  } state_t;

  localparam int NUM_SLOTS = 3;
  localparam int SLOT_W    = 2;

  // Scan index that selects the snooze entry instead of a slot.
  localparam logic [SLOT_W-1:0] SNOOZE_IDX = 2'd3;

  localparam logic [63:0] DEFAULT_DAY_SECS = 64'd86400;

endpackage

// File: rtl/alarm_slot_bank.sv
// Storage for the alarm slots. One write port (host), one fire-update port
// (scheduler) and a combinational read port used by the shared comparator.
// A host write to a slot always beats a fire update of the same slot.
module alarm_slot_bank
  import alarm_pkg::*;
#(
  parameter logic [63:0] DAY_SECS = DEFAULT_DAY_SECS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic [63:0]          wr_stamp,
  input  logic                 wr_enable,
  input  logic                 wr_repeat,
  input  logic                 fire_en,
  input  logic [SLOT_W-1:0]    fire_slot,
  input  logic [SLOT_W-1:0]    rd_slot,
  output logic [63:0]          rd_stamp,
  output logic                 rd_enable,
  output logic [NUM_SLOTS-1:0] enabled_mask
);

  logic [63:0] stamp_all [NUM_SLOTS];

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic [63:0] stamp_reg;
      logic        enable_reg;
      logic        repeat_reg;

      // Per-slot state: host write first, otherwise reschedule or disarm on fire.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stamp_reg  <= '0;
          enable_reg <= 1'b0;
          repeat_reg <= 1'b0;
        end else if (wr_en && (wr_slot == SLOT_W'(gi))) begin
          stamp_reg  <= wr_stamp;
          enable_reg <= wr_enable;
          repeat_reg <= wr_repeat;
        end else if (fire_en && (fire_slot == SLOT_W'(gi))) begin
          if (repeat_reg) begin
            stamp_reg <= stamp_reg + DAY_SECS;
          end else begin
            enable_reg <= 1'b0;
          end
        end
      end

      assign stamp_all[gi]    = stamp_reg;
      assign enabled_mask[gi] = enable_reg;
    end
  endgenerate

  // Read mux feeding the comparator; out-of-range index reads as disabled.
  always_comb begin
    rd_stamp  = '0;
    rd_enable = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (rd_slot == SLOT_W'(i)) begin
        rd_stamp  = stamp_all[i];
        rd_enable = enabled_mask[i];
      end
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm scheduler: on each tick, walks slot0..slot2 then the snooze entry
// through one shared 64-bit comparator, rings for the first due entry and
// holds the ring until stop, snooze or the ring timeout.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter logic [63:0] DAY_SECS    = DEFAULT_DAY_SECS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic [63:0]          counter,
  input  logic                 wr_en,
  input  logic [SLOT_W-1:0]    wr_slot,
  input  logic [63:0]          wr_stamp,
  input  logic                 wr_enable,
  input  logic                 wr_repeat,
  input  logic                 stop_req,
  input  logic                 snooze_req,
  output logic                 ring,
  output logic [SLOT_W-1:0]    ring_slot,
  output logic [NUM_SLOTS-1:0] enabled_mask,
  output logic                 snooze_pending,
  output logic                 busy
);

  state_t              state_reg, state_next;
  logic [SLOT_W-1:0]   scan_idx_reg;
  logic                ring_reg;
  logic [SLOT_W-1:0]   ring_slot_reg;
  logic [31:0]         ring_timer_reg;
  logic [63:0]         snooze_stamp_reg;
  logic                snooze_valid_reg;
  logic [SLOT_W-1:0]   snooze_slot_reg;

  logic [63:0]         rd_stamp;
  logic                rd_enable;
  logic                is_snooze;
  logic [63:0]         entry_stamp;
  logic                entry_valid;
  logic [SLOT_W-1:0]   entry_slot;
  logic                entry_due;
  logic                wr_hit;
  logic                fire;
  logic                arm_snooze;

  alarm_slot_bank #(.DAY_SECS(DAY_SECS)) u_bank (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_slot      (wr_slot),
    .wr_stamp     (wr_stamp),
    .wr_enable    (wr_enable),
    .wr_repeat    (wr_repeat),
    .fire_en      (fire && !is_snooze),
    .fire_slot    (scan_idx_reg),
    .rd_slot      (scan_idx_reg),
    .rd_stamp     (rd_stamp),
    .rd_enable    (rd_enable),
    .enabled_mask (enabled_mask)
  );

  // Select the entry under test and evaluate it with the single comparator.
  // A write landing on that entry's slot this cycle suppresses its fire.
  always_comb begin
    is_snooze   = (scan_idx_reg == SNOOZE_IDX);
    entry_stamp = is_snooze ? snooze_stamp_reg : rd_stamp;
    entry_valid = is_snooze ? snooze_valid_reg : rd_enable;
    entry_slot  = is_snooze ? snooze_slot_reg  : scan_idx_reg;
    entry_due   = entry_valid && (entry_stamp <= counter);
    wr_hit      = wr_en && (wr_slot == entry_slot);
  end

  // Next-state logic; stop beats snooze when both arrive together.
  always_comb begin
    state_next = state_reg;
    fire       = 1'b0;
    arm_snooze = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (tick) state_next = ST_SCAN;
      end
      ST_SCAN: begin
        if (entry_due && !wr_hit) begin
          fire       = 1'b1;
          state_next = ST_RING;
        end else if (is_snooze) begin
          state_next = ST_IDLE;
        end
      end
      ST_RING: begin
        if (stop_req) begin
          state_next = ST_IDLE;
        end else if (snooze_req) begin
          arm_snooze = 1'b1;
          state_next = ST_IDLE;
        end else if (tick && (ring_timer_reg == 32'(RING_SECS - 1))) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM, scan pointer and registered ring output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      scan_idx_reg <= '0;
      ring_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      scan_idx_reg <= (state_reg == ST_SCAN) ? scan_idx_reg + 1'b1 : '0;
      ring_reg     <= (state_next == ST_RING);
    end
  end

  // Latch the ringing slot and run the ring timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ring_slot_reg  <= '0;
      ring_timer_reg <= '0;
    end else if (fire) begin
      ring_slot_reg  <= entry_slot;
      ring_timer_reg <= '0;
    end else if ((state_reg == ST_RING) && tick) begin
      ring_timer_reg <= ring_timer_reg + 32'd1;
    end
  end

  // Snooze entry: armed from RING, consumed on fire, cancelled by a rewrite of its slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snooze_stamp_reg <= '0;
      snooze_valid_reg <= 1'b0;
      snooze_slot_reg  <= '0;
    end else if (arm_snooze) begin
      snooze_stamp_reg <= counter + 64'(SNOOZE_SECS);
      snooze_valid_reg <= 1'b1;
      snooze_slot_reg  <= ring_slot_reg;
    end else if (fire && is_snooze) begin
      snooze_valid_reg <= 1'b0;
    end else if (wr_en && (wr_slot == snooze_slot_reg)) begin
      snooze_valid_reg <= 1'b0;
    end
  end

  assign ring           = ring_reg;
  assign ring_slot      = ring_slot_reg;
  assign snooze_pending = snooze_valid_reg;
  assign busy           = (state_reg != ST_IDLE);

endmodule
